// File: rtl/dbg_line_cap_pkg.sv
// Shared types and constants for the debug line grabber.
package dbg_line_cap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_SEEK    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_e;

  localparam logic [7:0] HDR_TAG = 8'hA5;

  function automatic logic [31:0] hdr_word(input logic [15:0] sel);
    return {HDR_TAG, 8'h00, sel};
  endfunction

endpackage

// File: rtl/dbg_fifo_fwft.sv
// First-word-fall-through FIFO: dual-port RAM, extra-bit pointers, registered head word.
// A word written in cycle N is presented at N+2; a pop moves to the next word at N+1.
module dbg_fifo_fwft #(
  parameter int FIFO_AW = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_n,
  input  logic        wr_en,
  input  logic [31:0] din,
  output logic        full,
  input  logic        rd_en,
  output logic [31:0] dout,
  output logic        empty
);

  localparam int DEPTH = 2**FIFO_AW;

  logic [31:0]      mem_r [DEPTH];
  logic [FIFO_AW:0] wptr_r;
  logic [FIFO_AW:0] rptr_r;
  logic [FIFO_AW:0] rptr_nxt_s;
  logic [31:0]      dout_r;
  logic             valid_r;
  logic             wr_ok_s;
  logic             pop_s;

  // Full counts the head register too, so depth is exactly 2**FIFO_AW words.
  assign full       = (wptr_r[FIFO_AW] != rptr_r[FIFO_AW]) &&
                      (wptr_r[FIFO_AW-1:0] == rptr_r[FIFO_AW-1:0]);
  assign wr_ok_s    = wr_en & ~full & clr_n;
  assign pop_s      = rd_en & valid_r;
  assign rptr_nxt_s = rptr_r + {{FIFO_AW{1'b0}}, pop_s};

  // RAM write port
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wptr_r[FIFO_AW-1:0]] <= din;
    end
  end

  // Pointers and head register; head always fetches the word after any pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= {(FIFO_AW+1){1'b0}};
      rptr_r  <= {(FIFO_AW+1){1'b0}};
      dout_r  <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else if (!clr_n) begin
      wptr_r  <= {(FIFO_AW+1){1'b0}};
      rptr_r  <= {(FIFO_AW+1){1'b0}};
      valid_r <= 1'b0;
    end else begin
      wptr_r  <= wptr_r + {{FIFO_AW{1'b0}}, wr_ok_s};
      rptr_r  <= rptr_nxt_s;
      dout_r  <= mem_r[rptr_nxt_s[FIFO_AW-1:0]];
      valid_r <= (wptr_r != rptr_nxt_s);
    end
  end

  assign dout  = dout_r;
  assign empty = ~valid_r;

endmodule

// File: rtl/dbg_line_capture.sv
// Debug line grabber: on an arm edge, waits for frame start, seeks line_sel and stores its words.
// Optional macro DBG_LINE_CAP_HDR_EN prepends a {8'hA5,8'h00,line_sel} header word per capture.
module dbg_line_capture
  import dbg_line_cap_pkg::*;
#(
  parameter int FIFO_AW = 10,
  parameter int LINE_W  = 16
) (
  input  logic              reg_clk,
  input  logic              nrst,
  input  logic [31:0]       vid_data,
  input  logic              vid_den,
  input  logic              vid_sol,
  input  logic              vid_sof,
  input  logic              arm,
  input  logic [LINE_W-1:0] line_sel,
  input  logic              fifo_nrst,
  input  logic              fifo_rd,
  output logic [31:0]       fifo_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              cap_done,
  output logic              cap_ovf,
  output logic [FIFO_AW:0]  cap_cnt
);

  cap_state_e        state_r;
  cap_state_e        state_pre_s;
  cap_state_e        state_nxt_s;
  logic [LINE_W-1:0] lcnt_r;
  logic [LINE_W-1:0] lcnt_nxt_s;
  logic              arm_q_r;
  logic              arm_edge_s;
  logic              wr_req_s;
  logic [31:0]       wr_din_s;
  logic              wr_acc_s;
  logic              ovf_set_s;
  logic              full_s;
  logic [FIFO_AW:0]  cap_cnt_r;
  logic              cap_ovf_r;
  logic              cap_done_r;
`ifdef DBG_LINE_CAP_HDR_EN
  logic [31:0]       sel_ext_s;
  assign sel_ext_s = 32'(line_sel);
`endif

  assign arm_edge_s = arm & ~arm_q_r;

  // Next state, line counter and write request
  always_comb begin
    state_pre_s = state_r;
    lcnt_nxt_s  = lcnt_r;
    wr_req_s    = 1'b0;
    wr_din_s    = vid_data;
    if (!fifo_nrst) begin
      state_pre_s = ST_IDLE;
    end else if (arm_edge_s) begin
      state_pre_s = ST_ARMED;
`ifdef DBG_LINE_CAP_HDR_EN
      wr_req_s    = 1'b1;
      wr_din_s    = hdr_word(sel_ext_s[15:0]);
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_pre_s = ST_IDLE;
        end
        ST_ARMED: begin
          if (!arm) begin
            state_pre_s = ST_IDLE;
          end else if (vid_sof) begin
            lcnt_nxt_s = {{(LINE_W-1){1'b0}}, 1'b1};
            if (line_sel == {LINE_W{1'b0}}) begin
              state_pre_s = ST_CAPTURE;
              wr_req_s    = vid_den;
            end else begin
              state_pre_s = ST_SEEK;
            end
          end else begin
            state_pre_s = ST_ARMED;
          end
        end
        ST_SEEK: begin
          if (!arm) begin
            state_pre_s = ST_IDLE;
          end else if (vid_sol) begin
            if (lcnt_r == line_sel) begin
              state_pre_s = ST_CAPTURE;
              wr_req_s    = vid_den;
            end else begin
              lcnt_nxt_s = lcnt_r + {{(LINE_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_pre_s = ST_SEEK;
          end
        end
        ST_CAPTURE: begin
          if (!arm) begin
            state_pre_s = ST_IDLE;
          end else if (vid_sol || vid_sof) begin
            state_pre_s = ST_DONE;
          end else begin
            wr_req_s = vid_den;
          end
        end
        ST_DONE: begin
          if (!arm) begin
            state_pre_s = ST_IDLE;
          end else begin
            state_pre_s = ST_DONE;
          end
        end
        default: begin
          state_pre_s = ST_IDLE;
        end
      endcase
    end
  end

  // A write that meets a full FIFO is dropped and ends the capture.
  assign ovf_set_s   = wr_req_s & full_s;
  assign wr_acc_s    = wr_req_s & ~full_s;
  assign state_nxt_s = ovf_set_s ? ST_DONE : state_pre_s;

  // FSM, line counter and arm edge register
  always_ff @(posedge reg_clk or negedge nrst) begin
    if (!nrst) begin
      state_r    <= ST_IDLE;
      lcnt_r     <= {LINE_W{1'b0}};
      arm_q_r    <= 1'b0;
      cap_done_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      lcnt_r     <= lcnt_nxt_s;
      arm_q_r    <= arm;
      cap_done_r <= (state_nxt_s == ST_DONE);
    end
  end

  // Capture word count and sticky overflow flag
  always_ff @(posedge reg_clk or negedge nrst) begin
    if (!nrst) begin
      cap_cnt_r <= {(FIFO_AW+1){1'b0}};
      cap_ovf_r <= 1'b0;
    end else if (!fifo_nrst) begin
      cap_cnt_r <= {(FIFO_AW+1){1'b0}};
    end else if (arm_edge_s) begin
      cap_cnt_r <= {{FIFO_AW{1'b0}}, wr_acc_s};
      cap_ovf_r <= ovf_set_s;
    end else begin
      cap_cnt_r <= cap_cnt_r + {{FIFO_AW{1'b0}}, wr_acc_s};
      cap_ovf_r <= cap_ovf_r | ovf_set_s;
    end
  end

  dbg_fifo_fwft #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (reg_clk),
    .rst_n (nrst),
    .clr_n (fifo_nrst),
    .wr_en (wr_acc_s),
    .din   (wr_din_s),
    .full  (full_s),
    .rd_en (fifo_rd),
    .dout  (fifo_data),
    .empty (fifo_empty)
  );

  assign fifo_full = full_s;
  assign cap_done  = cap_done_r;
  assign cap_ovf   = cap_ovf_r;
  assign cap_cnt   = cap_cnt_r;

endmodule

// File: tb/tb_dbg_line_capture.sv
// Scoreboard bench for dbg_line_capture (small FIFO so overflow is reachable).
module tb_dbg_line_capture;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef DBG_LINE_CAP_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        reg_clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] vid_data = 32'h0;
  logic        vid_den = 1'b0;
  logic        vid_sol = 1'b0;
  logic        vid_sof = 1'b0;
  logic        arm = 1'b0;
  logic [15:0] line_sel = 16'h0;
  logic        fifo_nrst = 1'b1;
  logic        fifo_rd = 1'b0;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic        cap_done;
  logic        cap_ovf;
  logic [AW:0] cap_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  dbg_line_capture #(.FIFO_AW(AW), .LINE_W(16)) dut (
    .reg_clk(reg_clk), .nrst(nrst), .vid_data(vid_data), .vid_den(vid_den),
    .vid_sol(vid_sol), .vid_sof(vid_sof), .arm(arm), .line_sel(line_sel),
    .fifo_nrst(fifo_nrst), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .cap_done(cap_done),
    .cap_ovf(cap_ovf), .cap_cnt(cap_cnt)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic tick();
    @(posedge reg_clk);
    #1;
  endtask

  task automatic vid_idle();
    vid_den = 1'b0; vid_sol = 1'b0; vid_sof = 1'b0; vid_data = 32'h0;
  endtask

  task automatic do_arm(input logic [15:0] sel);
    line_sel = sel;
    arm = 1'b1;
    if (HDR != 0) exp_q.push_back({8'hA5, 8'h00, sel});
    tick();
  endtask

  // One video word; pushed to the scoreboard when it belongs to the expected capture.
  task automatic vid_word(input int l, input int p, input bit push);
    vid_sof = (l == 0 && p == 0);
    vid_sol = (p == 0);
    vid_den = 1'b1;
    vid_data = 32'(l * 16 + p);
    if (push && exp_q.size() < DEPTH) exp_q.push_back(32'(l * 16 + p));
    tick();
    if (p != 0) begin vid_sol = 1'b0; vid_sof = 1'b0; end
  endtask

  task automatic drive_frame(input int nl, input int nw, input int cap_line, input bit push);
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < nw; p++) vid_word(l, p, push && l == cap_line);
      vid_idle(); tick(); tick();
    end
  endtask

  task automatic drain(input string name, input int n);
    logic [31:0] exp;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 8 && fifo_empty; w++) tick();
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (fifo_empty) begin
        errors++; $display("FAIL %s word %0d: fifo_empty still 1, required data %h", name, i, exp);
      end else if (fifo_data !== exp) begin
        errors++; $display("FAIL %s word %0d: got %h, required %h", name, i, fifo_data, exp);
      end
      fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
    end
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++; $display("FAIL %s drained: fifo_empty=%b, required 1", name, fifo_empty);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; tick(); tick();
    checks++;
    if ({fifo_empty, fifo_full, cap_done, cap_ovf} !== 4'b1000 || fifo_data !== 32'h0 || cap_cnt !== 5'd0) begin
      errors++;
      $display("FAIL reset: empty=%b full=%b done=%b ovf=%b data=%h cnt=%0d, required 1 0 0 0 0 0",
               fifo_empty, fifo_full, cap_done, cap_ovf, fifo_data, cap_cnt);
    end
    nrst = 1'b1; tick();
  endtask

  task automatic test_mid_line();
    do_arm(16'd2);
    drive_frame(4, 8, 2, 1'b1);
    checks++;
    if (cap_cnt !== 5'(8 + HDR) || cap_done !== 1'b1 || cap_ovf !== 1'b0 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL mid_line status: cnt=%0d done=%b ovf=%b full=%b, required %0d 1 0 0",
               cap_cnt, cap_done, cap_ovf, fifo_full, 8 + HDR);
    end
    drain("mid_line", 8 + HDR);
    arm = 1'b0; tick();
    checks++;
    if (cap_done !== 1'b0) begin
      errors++; $display("FAIL mid_line disarm: cap_done=%b, required 0", cap_done);
    end
  endtask

  task automatic test_line0();
    do_arm(16'd0);
    for (int p = 0; p < 8; p++) begin
      if (p == 1) begin
        checks++;
        if (fifo_empty !== 1'(HDR == 0) || cap_cnt !== 5'(HDR + 1)) begin
          errors++; $display("FAIL line0 N+1: empty=%b cnt=%0d, required %b %0d",
                             fifo_empty, cap_cnt, 1'(HDR == 0), HDR + 1);
        end
      end
      if (p == 2) begin
        checks++;
        if (fifo_empty !== 1'b0 || fifo_data !== exp_q[0]) begin
          errors++; $display("FAIL line0 N+2: empty=%b data=%h, required 0 %h",
                             fifo_empty, fifo_data, exp_q[0]);
        end
      end
      vid_word(0, p, 1'b1);
    end
    vid_idle(); tick();
    for (int l = 1; l < 4; l++) begin
      for (int p = 0; p < 8; p++) vid_word(l, p, 1'b0);
      vid_idle(); tick();
    end
    checks++;
    if (cap_cnt !== 5'(8 + HDR) || cap_done !== 1'b1) begin
      errors++; $display("FAIL line0 status: cnt=%0d done=%b, required %0d 1", cap_cnt, cap_done, 8 + HDR);
    end
    drain("line0", 8 + HDR);
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0; tick();
    checks++;
    if (fifo_empty !== 1'b1 || cap_cnt !== 5'(8 + HDR)) begin
      errors++; $display("FAIL line0 pop_empty: empty=%b cnt=%0d, required 1 %0d", fifo_empty, cap_cnt, 8 + HDR);
    end
    arm = 1'b0; tick();
  endtask

  task automatic test_overflow();
    do_arm(16'd1);
    drive_frame(3, 20, 1, 1'b1);
    checks++;
    if (cap_ovf !== 1'b1 || cap_done !== 1'b1 || fifo_full !== 1'b1 || cap_cnt !== 5'(DEPTH)) begin
      errors++; $display("FAIL overflow: ovf=%b done=%b full=%b cnt=%0d, required 1 1 1 %0d",
                         cap_ovf, cap_done, fifo_full, cap_cnt, DEPTH);
    end
    checks++;
    if (fifo_data !== exp_q[0]) begin
      errors++; $display("FAIL overflow head: got %h, required %h", fifo_data, exp_q[0]);
    end
  endtask

  task automatic test_async_reset();
    vid_sol = 1'b0; vid_den = 1'b1; vid_data = 32'h55;
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({fifo_empty, fifo_full, cap_done, cap_ovf} !== 4'b1000 || fifo_data !== 32'h0 || cap_cnt !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: empty=%b full=%b done=%b ovf=%b data=%h cnt=%0d, required 1 0 0 0 0 0",
               fifo_empty, fifo_full, cap_done, cap_ovf, fifo_data, cap_cnt);
    end
    exp_q.delete();
    vid_idle(); arm = 1'b0; tick();
    nrst = 1'b1; tick();
  endtask

  task automatic test_arm_abort();
    do_arm(16'd2);
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 8; p++) begin
        if (l == 1 && p == 3) arm = 1'b0;
        vid_word(l, p, 1'b0);
      end
      vid_idle(); tick();
    end
    checks++;
    if (cap_done !== 1'b0 || fifo_empty !== 1'(exp_q.size() == 0) || cap_cnt !== 5'(HDR)) begin
      errors++; $display("FAIL arm_abort: done=%b empty=%b cnt=%0d, required 0 %b %0d",
                         cap_done, fifo_empty, cap_cnt, 1'(exp_q.size() == 0), HDR);
    end
    do_arm(16'd2);
    drive_frame(4, 8, 2, 1'b1);
    checks++;
    if (cap_done !== 1'b1 || cap_cnt !== 5'(8 + HDR)) begin
      errors++; $display("FAIL rearm: done=%b cnt=%0d, required 1 %0d", cap_done, cap_cnt, 8 + HDR);
    end
    drain("rearm", exp_q.size());
    arm = 1'b0; tick();
  endtask

  task automatic test_fifo_clear();
    do_arm(16'd1);
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 8; p++) begin
        if (l == 1 && p == 4) fifo_nrst = 1'b0;
        vid_word(l, p, 1'b0);
        if (l == 1 && p == 4) begin
          fifo_nrst = 1'b1;
          checks++;
          if (fifo_empty !== 1'b1 || cap_cnt !== 5'd0 || cap_done !== 1'b0) begin
            errors++; $display("FAIL fifo_clear: empty=%b cnt=%0d done=%b, required 1 0 0",
                               fifo_empty, cap_cnt, cap_done);
          end
        end
      end
      vid_idle(); tick();
    end
    checks++;
    if (fifo_empty !== 1'b1 || cap_cnt !== 5'd0) begin
      errors++; $display("FAIL fifo_clear idle: empty=%b cnt=%0d, required 1 0", fifo_empty, cap_cnt);
    end
    exp_q.delete();
    arm = 1'b0; tick();
  endtask

`ifdef DBG_LINE_CAP_HDR_EN
  task automatic test_header();
    do_arm(16'd3);
    drive_frame(4, 8, 3, 1'b1);
    checks++;
    if (cap_cnt !== 5'd9 || exp_q[0] !== 32'hA500_0003) begin
      errors++; $display("FAIL header: cnt=%0d head_exp=%h, required 9 a5000003", cap_cnt, exp_q[0]);
    end
    drain("header", 9);
    arm = 1'b0; tick();
  endtask
`endif

  initial begin
    test_reset();
    arm = 1'b0; tick();
    test_mid_line();
    test_line0();
    test_overflow();
    test_async_reset();
    test_arm_abort();
    test_fifo_clear();
`ifdef DBG_LINE_CAP_HDR_EN
    test_header();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
